// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between a sequencing client and shift_seq_ctrl.
// The master issues start and operands; the slave returns status and results.
interface shift_seq_ctrl_if #(
   parameter int unsigned CNT_W = 5
);
   logic             start;
   logic [15:0]      din;
   logic [CNT_W-1:0] cnt;
   logic             dir;
   logic             fill;
   logic             busy;
   logic             done;
   logic [15:0]      result;
   logic [CNT_W-1:0] ones_out;

   modport master (
      output start, din, cnt, dir, fill,
      input  busy, done, result, ones_out
   );

   modport slave (
      input  start, din, cnt, dir, fill,
      output busy, done, result, ones_out
   );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Load/shift/capture sequencer for a 16-bit shift register, counting shifted-out ones.
// Optional macro SHIFT_SEQ_CTRL_ROTATE_EN feeds LSB_out back as the right-shift serial input.
module shift_seq_ctrl #(
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned MAX_SHIFT = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   shift_seq_ctrl_if.slave  bus,
   input  logic             i_sr_msb,
   input  logic             i_sr_lsb,
   input  logic [15:0]      i_sr_q,
   output logic             o_sr_ld,
   output logic             o_sr_shl_en,
   output logic             o_sr_shr_en,
   output logic [15:0]      o_sr_par_in,
   output logic             o_sr_ser_in_l
);

   localparam logic [CNT_W-1:0] MaxShiftW = CNT_W'(MAX_SHIFT);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift,
      StDone
   } state_e;

   state_e           r_state;
   state_e           w_state_next;

   logic [15:0]      r_din;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dir;
   logic             r_fill;
   logic [CNT_W-1:0] r_shift_cnt;
   logic [CNT_W-1:0] r_ones;
   logic [15:0]      r_result;

   logic             w_accept;
   logic [CNT_W-1:0] w_cnt_clamp;
   logic [CNT_W-1:0] w_shift_inc;
   logic             w_last;
   logic             w_out_bit;

   assign w_accept    = (r_state == StIdle) && bus.start;
   assign w_cnt_clamp = (bus.cnt > MaxShiftW) ? MaxShiftW : bus.cnt;
   assign w_shift_inc = r_shift_cnt + 1'b1;
   assign w_last      = (w_shift_inc == r_cnt);
   // Pre-shift sample of the bit about to fall off the register.
   assign w_out_bit   = r_dir ? i_sr_msb : i_sr_lsb;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (bus.start) w_state_next = StLoad;
         StLoad:  w_state_next = (r_cnt != '0) ? StShift : StDone;
         StShift: if (w_last) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_din       <= '0;
         r_cnt       <= '0;
         r_dir       <= 1'b0;
         r_fill      <= 1'b0;
         r_shift_cnt <= '0;
         r_ones      <= '0;
         r_result    <= '0;
      end else begin
         if (w_accept) begin
            r_din       <= bus.din;
            r_cnt       <= w_cnt_clamp;
            r_dir       <= bus.dir;
            r_fill      <= bus.fill;
            r_shift_cnt <= '0;
            r_ones      <= '0;
         end
         if (r_state == StShift) begin
            r_shift_cnt <= w_shift_inc;
            r_ones      <= r_ones + CNT_W'(w_out_bit);
         end
         if (r_state == StDone) begin
            r_result <= i_sr_q;
         end
      end
   end

   assign o_sr_ld     = (r_state == StLoad);
   assign o_sr_shl_en = (r_state == StShift) && r_dir;
   assign o_sr_shr_en = (r_state == StShift) && !r_dir;
   assign o_sr_par_in = r_din;

`ifdef SHIFT_SEQ_CTRL_ROTATE_EN
   assign o_sr_ser_in_l = o_sr_shr_en ? i_sr_lsb : r_fill;
`else
   assign o_sr_ser_in_l = r_fill;
`endif

   assign bus.busy     = (r_state != StIdle);
   assign bus.done     = (r_state == StDone);
   assign bus.result   = r_result;
   assign bus.ones_out = r_ones;

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller that sits directly upstream of the 16-bit shift register and drives its `ld`, `shl_en`, `shr_en`, `par_in` and `ser_in_l` inputs.
- On a `start` request it loads an operand, issues a programmed number of left or right shift enables, and counts the 1-bits shifted out via `MSB_out`/`LSB_out`.
- When the sequence finishes it captures the register's `par_out` as the result and raises a one-cycle `done` pulse.
- It is the control stage for shift-based arithmetic (shift-add multiply, normalisation) in the datapath.

## Interface
Parameters:
- `CNT_W`, 5: width of shift-count input and ones counter; must hold 16.
- `MAX_SHIFT`, 16: requested shift counts above this are clamped to it.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; asynchronous assert, active-low (0 = reset).
- `start` in 1: request; accepted only in IDLE.
- `din` in 16: operand; latched on accept.
- `cnt` in CNT_W: number of shifts, 0..MAX_SHIFT; latched on accept, clamped.
- `dir` in 1: 0 = right shift, 1 = left shift; latched on accept.
- `fill` in 1: serial fill bit for right shifts; latched on accept.
- `sr_msb` in 1: shift register `MSB_out`.
- `sr_lsb` in 1: shift register `LSB_out`.
- `sr_q` in 16: shift register `par_out`.
- `sr_ld` out 1: shift register load.
- `sr_shl_en` out 1: left-shift enable.
- `sr_shr_en` out 1: right-shift enable.
- `sr_par_in` out 16: load data, equal to the latched `din`.
- `sr_ser_in_l` out 1: serial input for right shifts.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `result` out 16: `sr_q` captured in DONE; holds until the next DONE.
- `ones_out` out CNT_W: count of 1-bits shifted out in the last sequence; holds until the next accept.

## Operation
States and transitions:
- IDLE:
  - If `start`=1, latch `din`, `dir` and `fill`, latch `cnt` clamped to MAX_SHIFT, clear the shift counter and `ones_out`, then go to LOAD.
- LOAD: assert `sr_ld` for exactly one cycle.
  - Go to SHIFT if the latched count is nonzero, otherwise go to DONE.
- SHIFT: assert exactly one of `sr_shr_en` (`dir`=0) or `sr_shl_en` (`dir`=1) each cycle.
  - In the same cycle, add the outgoing bit to `ones_out`: `sr_lsb` for right shifts, `sr_msb` for left shifts. The sample is the pre-shift value.
  - Increment the shift counter. Go to DONE after the last shift cycle.
- DONE: register `result` <= `sr_q` at the clock edge that leaves DONE, and pulse `done`. Go to IDLE.

Output rules:
- `sr_ld`, `sr_shl_en` and `sr_shr_en` are Moore outputs and are mutually exclusive; all are 0 outside LOAD/SHIFT.
- `start` while busy is ignored; there is no queueing.
- Input changes after accept have no effect on the running sequence.
- `sr_shl_en` shifts zeros in, which is fixed by the register; `fill` is irrelevant to left shifts.

## Timing
- Reset (`rst`=0): state IDLE, and all outputs are 0: `sr_ld`, `sr_shl_en`, `sr_shr_en`, `sr_ser_in_l`, `busy`, `done`, `sr_par_in`, `result`, `ones_out`.
  - Reset asserted mid-sequence aborts it immediately; no `done` is produced.
- Sequence timeline, with `start` sampled at edge 0:
  - LOAD occupies cycle 1.
  - SHIFT occupies cycles 2..N+1.
  - DONE occupies cycle N+2, with `done` high in that cycle.
  - IDLE is reached at cycle N+3.
- `result` is valid from cycle N+3 onward.
- Total latency from accept to `done` is N+2 cycles. For N=0 it is 2 cycles.
- Back-to-back operation: `start` held high is re-accepted in the first IDLE cycle. Minimum period is N+3 cycles.
- Clamp: `cnt` > MAX_SHIFT behaves exactly as `cnt` = MAX_SHIFT.

## Configuration
- `SHIFT_SEQ_CTRL_ROTATE_EN`:
  - Defined: during right shifts `sr_ser_in_l` = `sr_lsb`, so a right sequence rotates; the latched `fill` is ignored.
  - Undefined: `sr_ser_in_l` = latched `fill` whenever not in reset.
  - Left shifts are unaffected in both cases.

## Test plan
The bench instantiates the shift register model driven by this block.
- `din`=16'hA5C3, `cnt`=4, `dir`=0, `fill`=0 -> `result`=16'h0A5C, `ones_out`=2, `done` 6 cycles after accept.
- `din`=16'h8001, `cnt`=1, `dir`=1 -> `result`=16'h0002, `ones_out`=1, exactly one `sr_shl_en` cycle.
- `cnt`=0, `din`=16'h1234 -> one `sr_ld` cycle, no shift enables, `result`=16'h1234, `done` 2 cycles after accept, `ones_out`=0.
- `cnt`=20, `din`=16'h0000, `dir`=0, `fill`=1, macro undefined -> exactly 16 `sr_shr_en` cycles, `result`=16'hFFFF, `ones_out`=0.
- `din`=16'h0001, `cnt`=1, `dir`=0, `fill`=0:
  - Macro defined -> `result`=16'h8000.
  - Macro undefined -> `result`=16'h0000.
  - `ones_out`=1 in both cases.
- Abort and busy handling:
  - `rst`=0 in the third SHIFT cycle of a `cnt`=8 run -> all outputs 0 immediately, no `done`.
  - A new `start` after release runs normally.
  - `start` pulsed while busy is ignored.
